// File: rtl/lcd_write_scheduler.sv
// Character-to-LCD write scheduler: turns accepted ASCII requests into data, address
// and clear transfers, tracking a 16x2 cursor and holding the bus for each LCD busy time.
module lcd_write_scheduler #(
    parameter int CMD_WAIT = 1112,
    parameter int CLR_WAIT = 45600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       init_done,
    input  logic       char_valid,
    input  logic [7:0] char_data,
    output logic       char_ready,
    output logic       enable,
    input  logic       en_done,
    output logic       rs,
    output logic [7:0] db_out,
    output logic [3:0] cursor_col,
    output logic       cursor_line,
    output logic       busy,
    output logic [3:0] state_dbg
);

    typedef enum logic [3:0] {
        IDLE, READY,
        WR_ISSUE, WR_WAIT, WR_HOLD,
        AD_ISSUE, AD_WAIT, AD_HOLD,
        CL_ISSUE, CL_WAIT, CL_HOLD
    } state_t;

    localparam int MAX_WAIT = (CLR_WAIT > CMD_WAIT) ? CLR_WAIT : CMD_WAIT;
    localparam int CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(CMD_WAIT - 1);
    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_WAIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic             enable_q, enable_d;
    logic             rs_q, rs_d;
    logic [7:0]       db_q, db_d;
    logic [3:0]       col_q, col_d;
    logic             line_q, line_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        rs_d    = rs_q;
        db_d    = db_q;
        col_d   = col_q;
        line_d  = line_q;
        cnt_d   = '0;
        case (state_q)
            IDLE: if (init_done) state_d = READY;
            READY: begin
                if (char_valid) begin
                    if (char_data >= 8'h20 && char_data <= 8'h7E) begin
                        state_d = WR_ISSUE;
                        rs_d    = 1'b1;
                        db_d    = char_data;
                    end else if (char_data == 8'h0C) begin
                        state_d = CL_ISSUE;
                        rs_d    = 1'b0;
                        db_d    = 8'h01;
                    end else if (char_data == 8'h0D) begin
                        state_d = AD_ISSUE;
                        col_d   = 4'd0;
                        line_d  = ~line_q;
                        rs_d    = 1'b0;
                        db_d    = {1'b1, ~line_q, 6'b0};
                    end
                end
            end
            WR_ISSUE: state_d = WR_WAIT;
            AD_ISSUE: state_d = AD_WAIT;
            CL_ISSUE: state_d = CL_WAIT;
            WR_WAIT:  if (en_done) state_d = WR_HOLD;
            AD_WAIT:  if (en_done) state_d = AD_HOLD;
            CL_WAIT:  if (en_done) state_d = CL_HOLD;
            WR_HOLD: begin
                if (cnt_q == CMD_LAST) begin
                    if (col_q != 4'd15) begin
                        col_d   = col_q + 4'd1;
                        state_d = READY;
                    end else begin
                        // End of line: wrap to the other line and reposition the LCD address.
                        col_d   = 4'd0;
                        line_d  = ~line_q;
                        state_d = AD_ISSUE;
                        rs_d    = 1'b0;
                        db_d    = {1'b1, ~line_q, 6'b0};
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            AD_HOLD: begin
                if (cnt_q == CMD_LAST) state_d = READY;
                else cnt_d = cnt_q + CNT_ONE;
            end
            CL_HOLD: begin
                if (cnt_q == CLR_LAST) begin
                    state_d = READY;
                    col_d   = 4'd0;
                    line_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
        enable_d = (state_d == WR_ISSUE) || (state_d == AD_ISSUE) || (state_d == CL_ISSUE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            enable_q <= 1'b0;
            rs_q     <= 1'b0;
            db_q     <= 8'h00;
            col_q    <= 4'd0;
            line_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            enable_q <= enable_d;
            rs_q     <= rs_d;
            db_q     <= db_d;
            col_q    <= col_d;
            line_q   <= line_d;
            cnt_q    <= cnt_d;
        end
    end

    assign char_ready  = (state_q == READY);
    assign busy        = (state_q != READY);
    assign enable      = enable_q;
    assign rs          = rs_q;
    assign db_out      = db_q;
    assign cursor_col  = col_q;
    assign cursor_line = line_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_lcd_write_scheduler.sv
// Directed bench for lcd_write_scheduler with a small strobe-generator responder.
module tb_lcd_write_scheduler;

    logic       clk = 1'b0;
    logic       rst, init_done, char_valid, en_done;
    logic [7:0] char_data;
    logic       char_ready, enable, rs, cursor_line, busy;
    logic [7:0] db_out;
    logic [3:0] cursor_col, state_dbg;

    int tests_run = 0;
    int fail_cnt  = 0;
    int en_count  = 0;

    lcd_write_scheduler #(.CMD_WAIT(4), .CLR_WAIT(10)) dut (
        .clk(clk), .rst(rst), .init_done(init_done),
        .char_valid(char_valid), .char_data(char_data), .char_ready(char_ready),
        .enable(enable), .en_done(en_done), .rs(rs), .db_out(db_out),
        .cursor_col(cursor_col), .cursor_line(cursor_line), .busy(busy),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (enable === 1'b1) en_count++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_char(input logic [7:0] c);
        char_valid = 1'b1;
        char_data  = c;
        step();
        char_valid = 1'b0;
    endtask

    // Answers one enable pulse with en_done `delay` cycles later, then counts hold cycles.
    task automatic xfer(input int delay, output logic rs_o, output logic [7:0] db_o, output int hold_n);
        int w = 0;
        while (enable !== 1'b1 && w < 50) begin
            step();
            w++;
        end
        check("enable_seen", enable, 1'b1);
        rs_o = rs;
        db_o = db_out;
        repeat (delay) step();
        en_done = 1'b1;
        step();
        en_done = 1'b0;
        hold_n = 0;
        while (char_ready !== 1'b1 && enable !== 1'b1 && hold_n < 20000) begin
            hold_n++;
            step();
        end
    endtask

    initial begin
        logic       r;
        logic [7:0] d;
        int         n, bad, base;

        rst = 1'b0; init_done = 1'b0; char_valid = 1'b0; char_data = 8'h00; en_done = 1'b0;
        repeat (3) step();
        check("rst_ready", char_ready, 1'b0);
        check("rst_busy", busy, 1'b1);
        check("rst_enable", enable, 1'b0);
        check("rst_rs", rs, 1'b0);
        check("rst_db", db_out, 8'h00);
        check("rst_col", cursor_col, 4'd0);
        check("rst_line", cursor_line, 1'b0);

        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (char_ready !== 1'b0 || busy !== 1'b1) bad++;
        end
        check("idle_before_init", bad, 0);
        init_done = 1'b1;
        step();
        check("ready_after_init", char_ready, 1'b1);
        check("busy_after_init", busy, 1'b0);

        // Single write of 'A'; a clear request held during the transfer must be ignored.
        base = en_count;
        char_valid = 1'b1;
        char_data  = 8'h41;
        step();
        char_data = 8'h0C;
        check("a_enable", enable, 1'b1);
        check("a_rs", rs, 1'b1);
        check("a_db", db_out, 8'h41);
        check("a_not_ready", char_ready, 1'b0);
        step();
        check("a_enable_one_cycle", enable, 1'b0);
        step();
        step();
        en_done = 1'b1;
        step();
        en_done = 1'b0;
        char_valid = 1'b0;
        check("a_hold_rs", rs, 1'b1);
        check("a_hold_db", db_out, 8'h41);
        n = 0;
        while (char_ready !== 1'b1 && n < 100) begin
            n++;
            step();
        end
        check("a_hold_cycles", n, 4);
        check("a_col", cursor_col, 4'd1);
        check("a_line", cursor_line, 1'b0);
        check("a_pulses", en_count - base, 1);

        en_done = 1'b1;
        step();
        en_done = 1'b0;
        check("stray_en_done_ready", char_ready, 1'b1);
        check("stray_en_done_enable", enable, 1'b0);

        // Fill the rest of line 0; the 16th character wraps with an address write.
        for (int i = 0; i < 15; i++) begin
            send_char(8'h42 + 8'(i));
            xfer(2, r, d, n);
        end
        check("wrap_last_rs", r, 1'b1);
        check("wrap_last_db", d, 8'h50);
        check("wrap_last_hold", n, 4);
        xfer(1, r, d, n);
        check("wrap_addr_rs", r, 1'b0);
        check("wrap_addr_db", d, 8'hC0);
        check("wrap_addr_hold", n, 4);
        check("wrap_pulses", en_count - base, 17);
        check("wrap_col", cursor_col, 4'd0);
        check("wrap_line", cursor_line, 1'b1);
        check("wrap_ready", char_ready, 1'b1);

        // Clear from line 1 column 7.
        for (int i = 0; i < 7; i++) begin
            send_char(8'h61 + 8'(i));
            xfer(1, r, d, n);
        end
        check("pre_clr_col", cursor_col, 4'd7);
        check("pre_clr_line", cursor_line, 1'b1);
        send_char(8'h0C);
        xfer(2, r, d, n);
        check("clr_rs", r, 1'b0);
        check("clr_db", d, 8'h01);
        check("clr_hold", n, 10);
        check("clr_col", cursor_col, 4'd0);
        check("clr_line", cursor_line, 1'b0);
        check("clr_ready", char_ready, 1'b1);

        // Carriage return, then an unsupported control code.
        send_char(8'h0D);
        check("cr_line_now", cursor_line, 1'b1);
        xfer(2, r, d, n);
        check("cr_rs", r, 1'b0);
        check("cr_db", d, 8'hC0);
        check("cr_hold", n, 4);
        base = en_count;
        send_char(8'h07);
        check("bel_ready", char_ready, 1'b1);
        check("bel_enable", enable, 1'b0);
        repeat (3) step();
        check("bel_pulses", en_count - base, 0);
        check("bel_col", cursor_col, 4'd0);
        check("bel_line", cursor_line, 1'b1);

        // Fill line 1; wrap goes back to line 0 with address 0x80.
        for (int i = 0; i < 16; i++) begin
            send_char(8'h30 + 8'(i));
            xfer(1, r, d, n);
        end
        xfer(1, r, d, n);
        check("wrap1_rs", r, 1'b0);
        check("wrap1_db", d, 8'h80);
        check("wrap1_col", cursor_col, 4'd0);
        check("wrap1_line", cursor_line, 1'b0);

        // Reset in the middle of a write's wait phase with a request pending.
        send_char(8'h5A);
        xfer(1, r, d, n);
        check("pre_rst_col", cursor_col, 4'd1);
        send_char(8'h5B);
        step();
        char_valid = 1'b1;
        char_data  = 8'h5C;
        rst = 1'b0;
        step();
        rst = 1'b1;
        init_done = 1'b0;
        check("mid_rst_enable", enable, 1'b0);
        check("mid_rst_ready", char_ready, 1'b0);
        check("mid_rst_busy", busy, 1'b1);
        check("mid_rst_col", cursor_col, 4'd0);
        check("mid_rst_line", cursor_line, 1'b0);
        check("mid_rst_rs", rs, 1'b0);
        check("mid_rst_db", db_out, 8'h00);
        en_done = 1'b1;
        step();
        en_done = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (char_ready !== 1'b0 || enable !== 1'b0) bad++;
        end
        check("post_rst_no_accept", bad, 0);
        init_done = 1'b1;
        step();
        check("post_rst_ready", char_ready, 1'b1);
        step();
        char_valid = 1'b0;
        check("post_rst_accept_enable", enable, 1'b1);
        check("post_rst_accept_db", db_out, 8'h5C);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
